// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C target (and the matching master).
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA pads and derives edge flags plus START/STOP conditions.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   sda_rise;
  logic                   sda_fall;

  // Preset to 1 so a freshly reset target sees an idle bus and no false edges.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  assign sda_rise = sda & ~sda_prev;
  assign sda_fall = ~sda & sda_prev;

  // SCL must be stably high across both cycles; a coincident SCL edge makes it data.
  assign start_det = sda_fall & scl & scl_prev;
  assign stop_det  = sda_rise & scl & scl_prev;

endmodule

// File: rtl/i2c_target.sv
// 7-bit address I2C target: byte receive strobes, byte transmit from user data, open-drain SDA.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);

  i2c_tgt_state_e state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shifter;
  logic [7:0]     next_byte;
  logic           ack_flag;
  logic           scl;
  logic           sda;
  logic           scl_rise;
  logic           scl_fall;
  logic           start_det;
  logic           stop_det;
  logic           bit_in;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .nrst      (nrst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign bit_in    = scl_rise & scl;
  assign next_byte = {shifter[6:0], sda};

  // ack_flag marks the second half of an ACK slot: "SDA already driven" in
  // ADDR_ACK/WR_ACK, "master acknowledged" in RD_ACK.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shifter  <= 8'h00;
      ack_flag <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      addr_hit <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      addr_hit <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state    <= ADDR;
        busy     <= 1'b1;
        bit_cnt  <= 3'd0;
        sda_oe   <= 1'b0;
        ack_flag <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end

          ADDR: begin
            if (bit_in) begin
              shifter <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (next_byte[7:1] == TARGET_ADDR) begin
                  rw       <= next_byte[0];
                  addr_hit <= 1'b1;
                  ack_flag <= 1'b0;
                  state    <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_flag) begin
                sda_oe   <= 1'b1;
                ack_flag <= 1'b1;
              end else if (rw == I2C_READ) begin
                shifter <= tx_data;
                tx_load <= 1'b1;
                sda_oe  <= ~tx_data[7];
                bit_cnt <= 3'd0;
                state   <= RD_DATA;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= WR_DATA;
              end
            end
          end

          WR_DATA: begin
            if (bit_in) begin
              shifter <= next_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= next_byte;
                rx_valid <= 1'b1;
                ack_flag <= 1'b0;
                state    <= WR_ACK;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_flag) begin
                sda_oe   <= 1'b1;
                ack_flag <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= WR_DATA;
              end
            end
          end

          // MSB is already on the bus on entry; each fall advances one bit.
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe   <= 1'b0;
                ack_flag <= 1'b0;
                state    <= RD_ACK;
              end else begin
                sda_oe  <= ~shifter[6];
                shifter <= {shifter[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          RD_ACK: begin
            if (bit_in) begin
              if (sda == I2C_NACK) begin
                state <= WAIT_STOP;
              end else if (sda == I2C_ACK) begin
                ack_flag <= 1'b1;
              end
            end else if (scl_fall && ack_flag) begin
              shifter  <= tx_data;
              tx_load  <= 1'b1;
              sda_oe   <= ~tx_data[7];
              bit_cnt  <= 3'd0;
              ack_flag <= 1'b0;
              state    <= RD_DATA;
            end
          end

          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
